counter_mod: RTL and testbench
==============================

// Module: counter_mod
// PURPOSE
//  Parametrised, loadable up/down modulo counter; next generation of the 4-bit loadable counter.
//  Counts 0..limit (runtime-programmable), either wraps or saturates at the boundary,
//  and flags boundary events with a roll pulse and a sticky overflow bit.
//  Used as the timebase/event counter for blocks that need a non-power-of-2 period.
// PARAMETERS
//  WIDTH    8   counter width in bits (>=2)
//  MODE     0   boundary mode: MODE_WRAP (0) wraps; MODE_SAT (1) holds at the boundary
//  RST_VAL  0   dout value after reset; must be < 2**WIDTH
// PORTS
//  clk      in   1      clock, all logic on rising edge
//  rst_n    in   1      reset, synchronous, active-low
//  en       in   1      count enable
//  up       in   1      direction: 1 = increment, 0 = decrement
//  ld       in   1      load strobe
//  ld_val   in   WIDTH  load value
//  limit    in   WIDTH  terminal value; count range is 0..limit
//  clr_ovf  in   1      clear sticky overflow
//  dout     out  WIDTH  current count (registered)
//  at_lim   out  1      combinational: dout >= limit
//  at_zero  out  1      combinational: dout == 0
//  roll     out  1      registered 1-cycle pulse, one cycle after a boundary event
//  ovf      out  1      sticky boundary-event flag (registered)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): dout=RST_VAL, roll=0, ovf=0; overrides every other input.
//  - Priority per edge: rst_n > ld > en. When en=0 and ld=0, dout holds.
//  - Load: dout <= (ld_val > limit) ? limit : ld_val. en and up are ignored; no roll.
//  - Up (en=1, up=1):
//      dout <  limit: dout+1.
//      dout >= limit: boundary event; WRAP -> 0, SAT -> hold.
//  - Down (en=1, up=0):
//      dout >  0: dout-1.
//      dout == 0: boundary event; WRAP -> limit, SAT -> hold at 0.
//  - limit lowered below the current dout: up-count treats it as a boundary (WRAP -> 0);
//    down-count decrements normally.
//  - limit==0: up and down both produce a boundary event on every enabled cycle; dout stays 0.
//  - All arithmetic is WIDTH bits unsigned; a WIDTH-bit carry is never observable.
//  - roll: high for exactly the one cycle after each boundary-event edge. Sustained en at the
//    boundary in SAT mode makes roll high on every cycle.
//  - ovf: set by a boundary event, cleared by clr_ovf. If both occur on the same edge, set wins.
//    clr_ovf while rst_n=0 has no additional effect.
//  - Latency: dout, roll and ovf update on the edge; at_lim and at_zero follow dout combinationally.
// STRUCTURE
//  - Package counter_pkg: MODE_WRAP / MODE_SAT localparams, shared with later counter variants.
//  - Single module, no sub-modules. Next-state logic is one combinational block; boundary-event
//    decode is a local wire shared by the dout, roll and ovf registers.
// TESTING  (WIDTH=8 unless noted)
//  1 Reset: rst_n=0 for 2 edges with en=1, up=1 -> dout=0, roll=0, ovf=0; at_zero=1.
//  2 Wrap up: MODE=0, limit=9, en=1, up=1 from 0 -> dout 0..9,0,1;
//    roll=1 only in the cycle after 9->0; ovf=1 from then on.
//  3 Wrap down: MODE=0, limit=9, dout=0, up=0, en=1 -> dout=9, roll pulses, then 8,7,...
//  4 Saturate: MODE=1, limit=9, dout=9, up=1, en held 3 cycles -> dout stays 9, roll=1 for 3 cycles;
//    dout=0, up=0 -> dout stays 0.
//  5 Load: limit=9, ld=1 ld_val=200 -> dout=9; ld=1 ld_val=3 with en=1 -> dout=3 (load wins); no roll.
//  6 Overflow and reset: clr_ovf on the same edge as a boundary event -> ovf stays 1;
//    clr_ovf alone -> ovf=0; rst_n=0 at dout=5 with en=1 -> dout=0 on the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: boundary-mode encodings.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_mod.sv
// Loadable up/down modulo counter over 0..limit with wrap or saturate at the
// boundary, a registered roll pulse and a sticky overflow flag.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODE    = MODE_WRAP,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] dout,
  output logic             at_lim,
  output logic             at_zero,
  output logic             roll,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_DOUT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic             SAT      = (MODE == MODE_SAT);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             roll_q, roll_d;
  logic             ovf_q,  ovf_d;
  logic             boundary;

  // Up-count treats any dout above a lowered limit as the boundary too.
  assign boundary = en && !ld && (up ? (dout_q >= limit) : (dout_q == '0));

  always_comb begin
    dout_d = dout_q;
    roll_d = boundary;
    ovf_d  = boundary || (ovf_q && !clr_ovf);

    if (ld) begin
      dout_d = (ld_val > limit) ? limit : ld_val;
    end else if (en) begin
      if (up) begin
        if (!boundary)  dout_d = dout_q + ONE;
        else if (!SAT)  dout_d = '0;
      end else begin
        if (!boundary)  dout_d = dout_q - ONE;
        else if (!SAT)  dout_d = limit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= RST_DOUT;
      roll_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      roll_q <= roll_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout    = dout_q;
  assign roll    = roll_q;
  assign ovf     = ovf_q;
  assign at_lim  = (dout_q >= limit);
  assign at_zero = (dout_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: a wrap and a saturate instance share stimulus
// and are compared every cycle against a behavioural model, plus literal pins.
module tb_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n, en, up, ld, clr_ovf;
  logic [7:0] ld_val, limit;

  logic [7:0] dout_w, dout_s;
  logic       at_lim_w, at_zero_w, roll_w, ovf_w;
  logic       at_lim_s, at_zero_s, roll_s, ovf_s;

  int errors = 0;
  int checks = 0;

  // model state, index 0 = wrap, 1 = saturate
  int md[2];
  bit mr[2];
  bit mo[2];

  always #5 clk = ~clk;

  counter_mod #(.WIDTH(8), .MODE(0), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .limit(limit), .clr_ovf(clr_ovf), .dout(dout_w), .at_lim(at_lim_w),
    .at_zero(at_zero_w), .roll(roll_w), .ovf(ovf_w)
  );

  counter_mod #(.WIDTH(8), .MODE(1), .RST_VAL(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .limit(limit), .clr_ovf(clr_ovf), .dout(dout_s), .at_lim(at_lim_s),
    .at_zero(at_zero_s), .roll(roll_s), .ovf(ovf_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural rules applied on a clock edge to one counter of the given mode.
  task automatic model_edge(input int m);
    int  lim, d;
    bit  ev;
    lim = int'(limit);
    d   = md[m];
    ev  = 1'b0;
    if (!rst_n) begin
      md[m] = 0; mr[m] = 0; mo[m] = 0;
      return;
    end
    if (ld) begin
      d = (int'(ld_val) > lim) ? lim : int'(ld_val);
    end else if (en && up) begin
      if (d < lim) d = d + 1;
      else begin ev = 1; if (m == 0) d = 0; end
    end else if (en) begin
      if (d > 0) d = d - 1;
      else begin ev = 1; if (m == 0) d = lim; end
    end
    md[m] = d;
    mr[m] = ev;
    mo[m] = ev | (mo[m] & ~clr_ovf);
  endtask

  task automatic compare_all();
    chk("wrap_dout",    dout_w,    md[0]);
    chk("wrap_at_lim",  at_lim_w,  md[0] >= int'(limit));
    chk("wrap_at_zero", at_zero_w, md[0] == 0);
    chk("wrap_roll",    roll_w,    mr[0]);
    chk("wrap_ovf",     ovf_w,     mo[0]);
    chk("sat_dout",     dout_s,    md[1]);
    chk("sat_at_lim",   at_lim_s,  md[1] >= int'(limit));
    chk("sat_at_zero",  at_zero_s, md[1] == 0);
    chk("sat_roll",     roll_s,    mr[1]);
    chk("sat_ovf",      ovf_s,     mo[1]);
  endtask

  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input int lv, input int lim, input logic c);
    rst_n   = r;
    en      = e;
    up      = u;
    ld      = l;
    ld_val  = 8'(lv);
    limit   = 8'(lim);
    clr_ovf = c;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  initial begin
    md[0] = 0; md[1] = 0; mr = '{0, 0}; mo = '{0, 0};

    // reset with count enabled
    cyc(0, 1, 1, 0, 0, 9, 0);
    cyc(0, 1, 1, 0, 0, 9, 0);
    chk("pin_reset_dout", dout_w, 0);
    chk("pin_reset_zero", at_zero_w, 1);
    chk("pin_reset_ovf",  ovf_s, 0);

    // up-count through the boundary
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 1, 0, 0, 9, 0);
      if (i == 8) chk("pin_up_at9", dout_w, 9);
      if (i == 9) begin
        chk("pin_wrap_to0", dout_w, 0);
        chk("pin_wrap_roll", roll_w, 1);
      end
    end
    chk("pin_wrap_dout2", dout_w, 2);
    chk("pin_wrap_roll0", roll_w, 0);
    chk("pin_wrap_ovf",   ovf_w, 1);
    chk("pin_sat_hold9",  dout_s, 9);
    chk("pin_sat_roll",   roll_s, 1);

    // down-count through zero
    cyc(1, 0, 0, 1, 0, 9, 0);
    cyc(1, 1, 0, 0, 0, 9, 0);
    chk("pin_down_wrap9", dout_w, 9);
    chk("pin_down_roll",  roll_w, 1);
    chk("pin_down_sat0",  dout_s, 0);
    cyc(1, 1, 0, 0, 0, 9, 0);
    chk("pin_down_8",     dout_w, 8);
    chk("pin_down_sat_roll", roll_s, 1);
    repeat (3) cyc(1, 1, 0, 0, 0, 9, 0);
    chk("pin_down_5", dout_w, 5);

    // hold with en=0
    repeat (2) cyc(1, 0, 1, 0, 0, 9, 0);
    chk("pin_hold_5", dout_w, 5);

    // sustained saturation at limit
    cyc(1, 0, 1, 1, 9, 9, 0);
    repeat (3) begin
      cyc(1, 1, 1, 0, 0, 9, 0);
      chk("pin_sat_stay9", dout_s, 9);
      chk("pin_sat_roll_each", roll_s, 1);
    end

    // load clamp and load priority over en
    cyc(1, 0, 1, 1, 200, 9, 0);
    chk("pin_ld_clamp", dout_w, 9);
    cyc(1, 1, 1, 1, 3, 9, 0);
    chk("pin_ld_wins", dout_s, 3);
    chk("pin_ld_noroll", roll_s, 0);

    // limit lowered below dout
    cyc(1, 0, 1, 1, 15, 20, 0);
    cyc(1, 1, 1, 0, 0, 9, 0);
    chk("pin_low_lim_wrap", dout_w, 0);
    chk("pin_low_lim_sat",  dout_s, 15);
    cyc(1, 0, 1, 1, 15, 20, 0);
    cyc(1, 1, 0, 0, 0, 9, 0);
    chk("pin_low_lim_down", dout_w, 14);
    chk("pin_low_lim_noroll", roll_w, 0);

    // limit == 0: every enabled cycle is a boundary
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("pin_lim0_dout", dout_w, 0);
    chk("pin_lim0_roll", roll_w, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // overflow clear vs set
    cyc(1, 0, 1, 0, 0, 9, 1);
    chk("pin_clr_ovf", ovf_w, 0);
    cyc(1, 0, 1, 1, 9, 9, 0);
    cyc(1, 1, 1, 0, 0, 9, 1);
    chk("pin_set_wins", ovf_w, 1);
    cyc(1, 0, 1, 0, 0, 9, 1);
    chk("pin_clr_alone", ovf_w, 0);

    // reset mid-count with en and clr_ovf asserted
    cyc(1, 0, 1, 1, 5, 9, 0);
    cyc(1, 1, 0, 0, 0, 9, 0);
    cyc(0, 1, 1, 0, 0, 9, 1);
    chk("pin_rst_dout", dout_w, 0);
    cyc(1, 1, 1, 0, 0, 9, 0);
    chk("pin_after_rst", dout_w, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
